// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the EX-stage divider.
//
// Holds the bus widths, the divider FSM state codes, the handshake level
// names and a small magnitude helper used when latching signed operands.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0]       ZeroWord   = '0;
    localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;

    // Divider FSM state codes.
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Handshake / mode levels.
    localparam logic DivStart          = 1'b1;
    localparam logic DivNotStart       = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivSigned         = 1'b1;
    localparam logic DivNotSigned      = 1'b0;

    // Two's-complement absolute value when the operand is signed and
    // negative; otherwise the raw bits. 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [RegBus-1:0] magnitude(input logic               sgn,
                                                    input logic [RegBus-1:0] v);
        return (sgn && v[RegBus-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// div -- multi-cycle 32-bit signed/unsigned radix-2 restoring divider.
//
// EX raises start_i with the operands and stalls until ready_o. Operands
// are sampled once in DivFree; 32 subtract-shift iterations follow, then
// sign correction and the result {remainder, quotient} is presented with
// ready_o, held until start_i drops.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o
//   annul_i       cancel the in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result valid
//
// Build option:
//   DIV_BYZERO_FAST_EN  when defined, a zero divisor short-circuits through
//                       DivByZero and returns 0 after one extra edge. When
//                       undefined, a zero divisor runs the full iteration.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    logic [1:0]        state;
    logic [64:0]       dividend;   // {rem[64:33], partial/quotient [32:0]}
    logic [RegBus-1:0] divisor;
    logic [5:0]        cnt;
    logic              neg_quot;   // operand signs differed (signed only)
    logic              neg_rem;    // dividend was negative (signed only)

    logic [RegBus-1:0] op1_mag;
    logic [RegBus-1:0] op2_mag;
    logic [32:0]       diff;
    logic [RegBus-1:0] quot_fix;
    logic [RegBus-1:0] rem_fix;

    always_comb begin
        op1_mag  = magnitude(signed_div_i, opdata1_i);
        op2_mag  = magnitude(signed_div_i, opdata2_i);
        // Trial subtraction; bit 32 set means the divisor did not fit.
        diff     = {1'b0, dividend[63:32]} - {1'b0, divisor};
        quot_fix = neg_quot ? (~dividend[31:0]  + 32'd1) : dividend[31:0];
        rem_fix  = neg_rem  ? (~dividend[64:33] + 32'd1) : dividend[64:33];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            dividend <= '0;
            divisor  <= '0;
            cnt      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= ZeroDouble;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result_o <= ZeroDouble;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        // Signs are captured here because the operand
                        // inputs are not looked at again.
                        divisor  <= op2_mag;
                        dividend <= {32'b0, op1_mag, 1'b0};
                        cnt      <= '0;
                        neg_quot <= (signed_div_i == DivSigned) &&
                                    (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                        neg_rem  <= (signed_div_i == DivSigned) && opdata1_i[RegBus-1];
`ifdef DIV_BYZERO_FAST_EN
                        if (opdata2_i == ZeroWord) state <= DivByZero;
                        else                       state <= DivOn;
`else
                        state    <= DivOn;
`endif
                    end
                end
`ifdef DIV_BYZERO_FAST_EN
                DivByZero: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        result_o <= ZeroDouble;
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end
`endif
                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        cnt      <= '0;
                        result_o <= ZeroDouble;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt != 6'd32) begin
                        if (diff[32]) dividend <= {dividend[63:0], 1'b0};
                        else          dividend <= {diff[31:0], dividend[31:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivNotStart) begin
                        result_o <= ZeroDouble;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end
                end
                default: begin
                    state    <= DivFree;
                    result_o <= ZeroDouble;
                    ready_o  <= DivResultNotReady;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb_div -- scoreboard bench for div. Requests push {expected result,
// expected ready cycle}; a monitor pops on each rising ready_o and also
// watches the hold/drop behaviour and the idle-zero result.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic start_s = 1'b0;
    logic rst_s   = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_s <= start_i;
        rst_s   <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the sign- or zero-extended
    // operands, truncated to 32 bits (covers the 0x80000000 / -1 wrap).
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'h0) begin
`ifdef DIV_BYZERO_FAST_EN
            q = 32'h0;
            r = 32'h0;
`else
            // Magnitude quotient all-ones, remainder |a|, then sign fix:
            // that leaves r = a and q = +1 for a negative signed dividend.
            q = (s && a[31]) ? 32'h1 : 32'hFFFFFFFF;
            r = a;
`endif
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    function automatic int lat(input logic [31:0] b);
`ifdef DIV_BYZERO_FAST_EN
        if (b == 32'h0) return 2;
`endif
        return 34;
    endfunction

    // Monitor.
    logic        prev_ready = 1'b0;
    logic [63:0] prev_res   = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_s) begin
                if (ready_o && !prev_ready) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_ready", {63'b0, ready_o}, 64'h0);
                    end else begin
                        e = sbq.pop_front();
                        check("result", result_o, e.res);
                        check("latency", 64'(cyc), 64'(e.cyc));
                    end
                end else if (prev_ready) begin
                    if (start_s) begin
                        check("hold_ready", {63'b0, ready_o}, 64'h1);
                        check("hold_result", result_o, prev_res);
                    end else begin
                        check("drop_ready", {63'b0, ready_o}, 64'h0);
                        check("drop_result", result_o, 64'h0);
                    end
                end else begin
                    if (result_o !== 64'h0) check("idle_result", result_o, 64'h0);
                end
            end
            prev_ready = ready_o;
            prev_res   = result_o;
        end
    end

    // One request; sup = 1 first presents it with annul_i high for a cycle.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic sup);
        exp_t e;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (sup) begin
            annul_i = 1'b1;
            @(negedge clk);
            annul_i = 1'b0;
        end
        e.res = model(s, a, b);
        e.cyc = cyc + lat(b);
        sbq.push_back(e);
        @(negedge clk);
        // Operands must be ignored once sampled.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        for (int t = 0; t < 100 && !ready_o; t++) @(negedge clk);
        if (!ready_o) begin
            check("ready_timeout", {63'b0, ready_o}, 64'h1);
            if (sbq.size() != 0) void'(sbq.pop_back());
        end
        for (int h = 0; h < hold; h++) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [31:0] a, b;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {63'b0, ready_o}, 64'h0);
        check("reset_result", result_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_div(1'b0, 32'd100,       32'd7,         2, 1'b0);
        do_div(1'b1, 32'hFFFFFFF9,  32'd2,         0, 1'b0);
        do_div(1'b1, 32'd7,         32'hFFFFFFFE,  1, 1'b0);
        do_div(1'b1, 32'h80000000,  32'hFFFFFFFF,  0, 1'b0);
        do_div(1'b0, 32'hFFFFFFFF,  32'd1,         3, 1'b0);
        do_div(1'b0, 32'd5,         32'd0,         1, 1'b0);
        do_div(1'b1, 32'd5,         32'd0,         0, 1'b0);
        do_div(1'b1, 32'hFFFFFFFB,  32'd0,         2, 1'b0);
        do_div(1'b0, 32'd100,       32'd7,         0, 1'b1);

        // Annul at E10, then an immediate 100/7.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_ready", {63'b0, ready_o}, 64'h0);
        do_div(1'b0, 32'd100, 32'd7, 1, 1'b0);

        // Reset at E20 mid-divide.
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFFF9;
        opdata2_i    = 32'd2;
        start_i      = 1'b1;
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("midrst_ready", {63'b0, ready_o}, 64'h0);
        check("midrst_result", result_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);

        // Random cases.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = $urandom_range(0, 1) ? 32'h1 : 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_div(s, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 64'(sbq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit signed/unsigned divider, the responder side of the EX-stage divide handshake. EX raises `start_i` with operands for DIV/DIVU and stalls the pipeline. This block runs a radix-2 restoring division and returns `{remainder, quotient}` with `ready_o`. EX writes the result to HI/LO.

## Interface
- No parameters; widths come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).
- Clock: one clock. Reset: synchronous, active-high.
- `clk  in  1` – clock; all state updates on the rising edge.
- `rst  in  1` – synchronous active-high reset.
- `signed_div_i  in  1` – 1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i  in  32` – dividend.
- `opdata2_i  in  32` – divisor.
- `start_i  in  1` – request; held high by EX until it sees `ready_o`.
- `annul_i  in  1` – cancel the in-flight divide (flush, exception).
- `result_o  out  64` – `{remainder[63:32], quotient[31:0]}`; reset value 0.
- `ready_o  out  1` – result valid; reset value 0.

## Operation
States (codes in the shared defines): `DivFree`, `DivByZero`, `DivOn`, `DivEnd`. Internal registers: 65-bit `dividend`, 32-bit `divisor`, 6-bit `cnt`.

- **DivFree**
  - If `start_i` = 1 and `annul_i` = 0, latch the operand magnitudes: two's-complement absolute value when `signed_div_i` = 1 and bit 31 = 1, else the raw value.
  - If the divisor = 0 → `DivByZero` (macro on). Otherwise `dividend` = `{32'b0, |op1|, 1'b0}`, `cnt` = 0 → `DivOn`.
  - `ready_o` = 0, `result_o` = 0.
- **DivOn**, one iteration per edge:
  - Compute `diff` = `{1'b0, dividend[63:32]}` − `{1'b0, divisor}` (33-bit).
  - If `diff[32]` = 1 (negative): `dividend` = `{dividend[63:0], 1'b0}`.
  - Else: `dividend` = `{diff[31:0], dividend[31:0], 1'b1}`.
  - `cnt` increments. When `cnt` = 32: apply sign correction, load `result_o`, set `ready_o` = 1 → `DivEnd`.
- **Sign correction** (signed only):
  - Quotient `dividend[31:0]` is negated if the operand signs differ.
  - Remainder `dividend[64:33]` is negated if the dividend is negative.
  - `0x80000000 / 0xFFFFFFFF` yields quotient `0x80000000` and remainder 0 (wrap, no trap).
- **DivByZero**: `result_o` = 0, `ready_o` = 1 → `DivEnd`.
- **DivEnd**
  - Hold `result_o` and `ready_o` while `start_i` = 1.
  - When `start_i` = 0: `ready_o` = 0, `result_o` = 0 → `DivFree`.
- **annul_i** = 1 in `DivOn`/`DivByZero` → `DivFree` next edge, `ready_o` stays 0. In `DivFree` it suppresses a start.
- **rst** = 1 at any edge, including mid-divide: all registers and outputs to 0, state `DivFree`.

## Timing
- E0 = the edge sampling `start_i` in `DivFree`.
- Normal divide: iterations at E1..E32; `ready_o`/`result_o` are valid after E33. EX stalls 34 cycles.
- Divide by zero (macro on): valid after E1.
- `ready_o` rises exactly once per accepted request and stays high until `start_i` falls. After that there is 1 edge back to `DivFree`; a new start is accepted on the following edge.
- Operand inputs are ignored after E0.
- `start_i` falling while in `DivOn` does not abort; only `annul_i` or `rst` abort.

## Configuration
- `DIV_BYZERO_FAST_EN` defined:
  - A zero divisor takes `DivByZero`.
  - Result 0, 2-cycle latency.
- Undefined:
  - No `DivByZero` state; a zero divisor runs the normal 32 iterations.
  - Magnitude quotient is `0xFFFFFFFF`, remainder is |dividend|, then sign correction as above.
  - Latency 34 cycles.

## Structure
- Shared defines header holds:
  - State codes (`DivFree`/`DivByZero`/`DivOn`/`DivEnd`, 2 bits).
  - `DivStart`/`DivNotStart`, `DivResultReady`/`DivResultNotReady`, `DivSigned`/`DivNotSigned`.
  - `RegBus`, `DoubleRegBus`, `ZeroWord`.
- No sub-module: the single subtract-shift step is inline. The FSM and datapath stay in one module.

## Test plan
- Unsigned 100 / 7: `result_o` = `{0x00000002, 0x0000000E}`; `ready_o` after E33 and held until `start_i` drops.
- Signed −7 / 2: quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Signed 7 / −2: quotient `0xFFFFFFFD`, remainder `0x00000001`.
- Signed `0x80000000 / 0xFFFFFFFF` → `{0, 0x80000000}`. Unsigned `0xFFFFFFFF / 1` → `{0, 0xFFFFFFFF}`.
- Divisor 0, dividend 5:
  - Macro on: `{0, 0}` after E1.
  - Macro off: `{0x00000005, 0xFFFFFFFF}` after E33.
- Annul and reset:
  - `annul_i` pulse at E10: `ready_o` never rises, FSM returns to `DivFree`; an immediate 100/7 then returns correct.
  - `rst` at E20: all outputs 0.
